uart_frame_scheduler: RTL and testbench
=======================================

Name: uart_frame_scheduler

Overview:
Sequences the byte stream into the UART byte transmitter. Arbitrates between two requesters: the image FIFO (camera frame, wrapped in serial-debug-assistant header/trailer) and a short message channel (status/text packets). Frames are atomic. Arbitration happens only at frame/packet boundaries. Sits between the image FIFO / message source and a valid/ready byte-level UART TX.

Parameters:
IMG_BYTES, 153600, bytes per image frame (240*320*2); counter width is $clog2(IMG_BYTES+1)
CMD, 8'h01, protocol command byte; header = CMD, ~CMD; trailer = ~CMD, CMD
TIMEOUT_CYC, 1000000, underrun watchdog limit in SYS_CLK cycles (used only with the optional feature)
PAD_BYTE, 8'h00, filler byte (used only with the optional feature)

Ports:
SYS_CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
FRAME_REQ  in  1  level: a captured frame is ready to send
IMG_EMPTY  in  1  image FIFO empty
IMG_DATA  in  8  image FIFO q; normal mode, valid the cycle after IMG_RDREQ
IMG_RDREQ  out  1  image FIFO read request, one-cycle pulse per byte
MSG_VALID  in  1  message byte valid
MSG_DATA  in  8  message byte
MSG_LAST  in  1  last byte of message packet, qualified by MSG_VALID
MSG_READY  out  1  message byte accepted when MSG_VALID&&MSG_READY
TX_DATA  out  8  byte to UART transmitter
TX_VALID  out  1  byte valid; held with TX_DATA stable until accepted
TX_READY  in  1  transmitter accepts byte when TX_VALID&&TX_READY
BUSY  out  1  high in any state other than IDLE
FRAME_DONE  out  1  one-cycle pulse after trailer byte CMD is accepted
ERR  out  1  sticky underrun flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, round-robin pointer selects image. RST mid-frame abandons the frame; no trailer is sent.
- States: IDLE, HDR0, HDR1, IMG_RD, IMG_WAIT, IMG_SEND, TRL0, TRL1, MSG.
- IDLE arbitration: FRAME_REQ=1 and MSG_VALID=1 -> grant the requester not served last. Only one requesting -> grant it. Grant takes one cycle. TX_VALID rises on the next cycle.
- HDR0 drives CMD; HDR1 drives ~CMD. Each advances on TX_READY.
- IMG_RD: if !IMG_EMPTY, pulse IMG_RDREQ and go to IMG_WAIT. If empty, stall with TX_VALID=0.
- IMG_WAIT: register IMG_DATA into TX_DATA, go to IMG_SEND.
- IMG_SEND: on accept, count+1. If count==IMG_BYTES go to TRL0, else go to IMG_RD.
- TRL0 drives ~CMD; TRL1 drives CMD. On TRL1 accept: pulse FRAME_DONE, set pointer=image-served, go to IDLE.
- IMG_RDREQ is never asserted outside IMG_RD, and never more than IMG_BYTES times per frame.
- MSG: TX_DATA=MSG_DATA, TX_VALID=MSG_VALID, MSG_READY=TX_READY (combinational pass-through). The byte accepted with MSG_LAST=1 sets pointer=msg-served and returns to IDLE. Message bytes are never interleaved into a frame.
- FRAME_REQ is sampled only in IDLE. Deassertion mid-frame is ignored.
- TX_DATA/TX_VALID must not change while TX_VALID=1 and TX_READY=0 (except in MSG pass-through, where the source obeys the same rule).

Optional Feature:
UART_SCHED_TIMEOUT_EN.
- Defined: a counter runs while the FSM is in IMG_RD with IMG_EMPTY=1. At TIMEOUT_CYC, set ERR (cleared only by RST) and fill the remaining frame bytes with PAD_BYTE without reading the FIFO. Trailer and FRAME_DONE follow normally.
- Undefined: IMG_RD stalls indefinitely; ERR=0.

Decomposition:
- Package uart_sched_pkg: state enum, default CMD, PAD_BYTE, grant encoding (GNT_IMG, GNT_MSG).
- One sub-module uart_rr_arb2: 2-way round-robin arbiter with last-served pointer and an update strobe.

Test Plan:
- IMG_BYTES=4, FIFO holds A0..A3, TX_READY=1 -> TX byte sequence 01,FE,A0,A1,A2,A3,FE,01; 4 IMG_RDREQ pulses; FRAME_DONE once.
- TX_READY toggles 1-of-3 cycles during a frame -> same byte sequence, TX_DATA stable while stalled, no extra reads.
- FRAME_REQ and 3-byte message (last flagged) both pending from reset -> frame first, then message. Both re-pending -> message before the next frame.
- FIFO empties after 2 bytes for 50 cycles, then refills -> TX_VALID=0 during the gap, output still 01,FE,A0..A3,FE,01.
- RST asserted after 5th byte accepted -> next cycle all outputs 0, IDLE. A new FRAME_REQ starts with header 01.
- With UART_SCHED_TIMEOUT_EN, TIMEOUT_CYC=10, FIFO empty after 1 byte -> ERR=1, output 01,FE,A0,00,00,00,FE,01.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART frame scheduler.
// States, grant encoding and the default protocol bytes live here so the
// scheduler and its arbiter agree on one definition.
package uart_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HDR0     = 4'd1,
        ST_HDR1     = 4'd2,
        ST_IMG_RD   = 4'd3,
        ST_IMG_WAIT = 4'd4,
        ST_IMG_SEND = 4'd5,
        ST_TRL0     = 4'd6,
        ST_TRL1     = 4'd7,
        ST_MSG      = 4'd8
    } sched_state_t;

    // Which requester owns the transmitter.
    typedef enum logic {
        GNT_IMG = 1'b0,
        GNT_MSG = 1'b1
    } gnt_t;

    // Protocol command byte: header is CMD,~CMD and trailer is ~CMD,CMD.
    localparam logic [7:0] DEF_CMD      = 8'h01;
    // Byte used to fill a frame whose image data never arrived.
    localparam logic [7:0] DEF_PAD_BYTE = 8'h00;

    // Header/trailer marker byte: either the command or its complement.
    function automatic logic [7:0] frame_marker(input logic [7:0] cmd, input logic invert);
        return invert ? ~cmd : cmd;
    endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter between the image frame path and the message
// path. The priority pointer only moves when the scheduler strobes 'upd'
// at the end of a frame or packet, so arbitration is per transfer, not per
// byte.
module uart_rr_arb2
    import uart_sched_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic req_img,
    input  logic req_msg,
    input  logic upd,
    input  logic upd_src,
    output logic gnt_valid,
    output logic gnt
);

    gnt_t prio_reg;
    gnt_t prio_next;

    // After a transfer completes, priority goes to the side that was not served.
    always_comb begin
        prio_next = prio_reg;
        if (upd) begin
            prio_next = (gnt_t'(upd_src) == GNT_IMG) ? GNT_MSG : GNT_IMG;
        end
    end

    // Priority pointer register; image side is favoured out of reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            prio_reg <= GNT_IMG;
        end else begin
            prio_reg <= prio_next;
        end
    end

    // Grant: sole requester wins outright, contention resolved by the pointer.
    always_comb begin
        gnt_valid = req_img | req_msg;
        gnt       = GNT_IMG;
        if (req_img && req_msg) begin
            gnt = prio_reg;
        end else if (req_msg) begin
            gnt = GNT_MSG;
        end
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// UART frame scheduler: feeds a valid/ready byte transmitter from either the
// image FIFO (wrapped in a CMD,~CMD header and ~CMD,CMD trailer) or a
// message channel passed straight through. Frames and packets are atomic;
// arbitration only happens in IDLE.
//
// Build option: define UART_SCHED_TIMEOUT_EN to enable the underrun
// watchdog. When the image FIFO stays empty for TIMEOUT_CYC cycles the
// sticky ERR flag is raised and the remainder of the frame is filled with
// PAD_BYTE. Without it the scheduler waits for data indefinitely and ERR=0.
module uart_frame_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned IMG_BYTES   = 153600,
    parameter logic [7:0]  CMD         = DEF_CMD,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  PAD_BYTE    = DEF_PAD_BYTE
) (
    input  logic       SYS_CLK,
    input  logic       RST,
    input  logic       FRAME_REQ,
    input  logic       IMG_EMPTY,
    input  logic [7:0] IMG_DATA,
    output logic       IMG_RDREQ,
    input  logic       MSG_VALID,
    input  logic [7:0] MSG_DATA,
    input  logic       MSG_LAST,
    output logic       MSG_READY,
    output logic [7:0] TX_DATA,
    output logic       TX_VALID,
    input  logic       TX_READY,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic       ERR
);

    localparam int CW = $clog2(IMG_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef UART_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    sched_state_t  state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    byte_reg, byte_next;
    logic          frame_done_reg, frame_done_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          pad_reg, pad_next;
    logic          err_reg, err_next;

    logic          arb_gnt_valid;
    logic          arb_gnt;
    logic          arb_upd;
    logic          arb_upd_src;

    assign cnt_inc = cnt_reg + CW'(1);

    uart_rr_arb2 u_arb (
        .clk       (SYS_CLK),
        .srst      (RST),
        .req_img   (FRAME_REQ),
        .req_msg   (MSG_VALID),
        .upd       (arb_upd),
        .upd_src   (arb_upd_src),
        .gnt_valid (arb_gnt_valid),
        .gnt       (arb_gnt)
    );

    // Next-state, datapath and output decode for the scheduler FSM.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        byte_next       = byte_reg;
        frame_done_next = 1'b0;
        to_cnt_next     = '0;
        pad_next        = pad_reg;
        err_next        = err_reg;
        TX_DATA         = 8'h00;
        TX_VALID        = 1'b0;
        MSG_READY       = 1'b0;
        IMG_RDREQ       = 1'b0;
        arb_upd         = 1'b0;
        arb_upd_src     = GNT_IMG;

        case (state_reg)
            ST_IDLE: begin
                // Every frame starts with a fresh byte count and real data.
                cnt_next = '0;
                pad_next = 1'b0;
                if (arb_gnt_valid) begin
                    state_next = (arb_gnt == GNT_MSG) ? ST_MSG : ST_HDR0;
                end
            end

            ST_HDR0: begin
                TX_DATA  = frame_marker(CMD, 1'b0);
                TX_VALID = 1'b1;
                if (TX_READY) state_next = ST_HDR1;
            end

            ST_HDR1: begin
                TX_DATA  = frame_marker(CMD, 1'b1);
                TX_VALID = 1'b1;
                if (TX_READY) state_next = ST_IMG_RD;
            end

            ST_IMG_RD: begin
                if (pad_reg) begin
                    // Underrun already declared: skip the FIFO entirely.
                    state_next = ST_IMG_WAIT;
                end else if (!IMG_EMPTY) begin
                    IMG_RDREQ  = 1'b1;
                    state_next = ST_IMG_WAIT;
                end else if (TIMEOUT_EN) begin
                    // Count consecutive empty cycles; the count drops back
                    // to zero as soon as the FIFO delivers again.
                    if (to_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
                        pad_next = 1'b1;
                        err_next = 1'b1;
                    end else begin
                        to_cnt_next = to_cnt_reg + TW'(1);
                    end
                end
            end

            ST_IMG_WAIT: begin
                // FIFO q is valid one cycle after the read request.
                byte_next  = pad_reg ? PAD_BYTE : IMG_DATA;
                state_next = ST_IMG_SEND;
            end

            ST_IMG_SEND: begin
                TX_DATA  = byte_reg;
                TX_VALID = 1'b1;
                if (TX_READY) begin
                    cnt_next   = cnt_inc;
                    state_next = (cnt_inc == CW'(IMG_BYTES)) ? ST_TRL0 : ST_IMG_RD;
                end
            end

            ST_TRL0: begin
                TX_DATA  = frame_marker(CMD, 1'b1);
                TX_VALID = 1'b1;
                if (TX_READY) state_next = ST_TRL1;
            end

            ST_TRL1: begin
                TX_DATA  = frame_marker(CMD, 1'b0);
                TX_VALID = 1'b1;
                if (TX_READY) begin
                    frame_done_next = 1'b1;
                    arb_upd         = 1'b1;
                    arb_upd_src     = GNT_IMG;
                    state_next      = ST_IDLE;
                end
            end

            ST_MSG: begin
                // Message bytes pass straight through until the last one.
                TX_DATA   = MSG_DATA;
                TX_VALID  = MSG_VALID;
                MSG_READY = TX_READY;
                if (MSG_VALID && TX_READY && MSG_LAST) begin
                    arb_upd     = 1'b1;
                    arb_upd_src = GNT_MSG;
                    state_next  = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            byte_reg       <= 8'h00;
            frame_done_reg <= 1'b0;
            to_cnt_reg     <= '0;
            pad_reg        <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            byte_reg       <= byte_next;
            frame_done_reg <= frame_done_next;
            to_cnt_reg     <= to_cnt_next;
            pad_reg        <= pad_next;
            err_reg        <= err_next;
        end
    end

    assign BUSY       = (state_reg != ST_IDLE);
    assign FRAME_DONE = frame_done_reg;
    assign ERR        = err_reg;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Self-checking bench for uart_frame_scheduler with a 4-byte image frame.
// Image FIFO and message source are small behavioural models; accepted TX
// bytes are logged and compared against hand-computed sequences.
module tb_uart_frame_scheduler;

    localparam int IMG_BYTES   = 4;
    localparam int TIMEOUT_CYC = 10;
`ifdef UART_SCHED_TIMEOUT_EN
    localparam int GAP_CYC = 5;
`else
    localparam int GAP_CYC = 50;
`endif

    logic       SYS_CLK   = 1'b0;
    logic       RST       = 1'b1;
    logic       FRAME_REQ = 1'b0;
    logic       TX_READY  = 1'b0;
    logic       IMG_EMPTY;
    logic [7:0] IMG_DATA;
    logic       IMG_RDREQ;
    logic       MSG_VALID;
    logic [7:0] MSG_DATA;
    logic       MSG_LAST;
    logic       MSG_READY;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       BUSY;
    logic       FRAME_DONE;
    logic       ERR;

    uart_frame_scheduler #(
        .IMG_BYTES   (IMG_BYTES),
        .CMD         (8'h01),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .PAD_BYTE    (8'h00)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .RST        (RST),
        .FRAME_REQ  (FRAME_REQ),
        .IMG_EMPTY  (IMG_EMPTY),
        .IMG_DATA   (IMG_DATA),
        .IMG_RDREQ  (IMG_RDREQ),
        .MSG_VALID  (MSG_VALID),
        .MSG_DATA   (MSG_DATA),
        .MSG_LAST   (MSG_LAST),
        .MSG_READY  (MSG_READY),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE),
        .ERR        (ERR)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    // ---------------- image FIFO model (normal mode: q valid after rdreq)
    logic [7:0] fifo_mem [0:63];
    int         fifo_wr = 0;
    int         fifo_rd = 0;
    logic [7:0] img_q   = 8'h00;
    assign IMG_EMPTY = (fifo_rd == fifo_wr);
    assign IMG_DATA  = img_q;

    always @(posedge SYS_CLK) begin
        if (RST) begin
            fifo_rd <= fifo_wr;
        end else if (IMG_RDREQ && (fifo_rd != fifo_wr)) begin
            img_q   <= fifo_mem[fifo_rd % 64];
            fifo_rd <= fifo_rd + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        fifo_mem[fifo_wr % 64] = b;
        fifo_wr = fifo_wr + 1;
    endtask

    // ---------------- message source model
    logic [7:0] msg_mem [0:15];
    logic       msg_lst [0:15];
    int         msg_n   = 0;
    int         msg_idx = 0;
    assign MSG_VALID = (msg_idx < msg_n);
    assign MSG_DATA  = msg_mem[msg_idx % 16];
    assign MSG_LAST  = msg_lst[msg_idx % 16];

    always @(posedge SYS_CLK) begin
        if (RST) begin
            msg_idx <= msg_n;
        end else if (MSG_VALID && MSG_READY) begin
            msg_idx <= msg_idx + 1;
        end
    end

    task automatic msg_push(input logic [7:0] b, input logic last);
        msg_mem[msg_n % 16] = b;
        msg_lst[msg_n % 16] = last;
        msg_n = msg_n + 1;
    endtask

    // ---------------- TX_READY pattern generator
    int cyc        = 0;
    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge SYS_CLK);
            #1;
            cyc = cyc + 1;
            TX_READY = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    // ---------------- scoreboard counters
    int total = 0;
    int bad   = 0;

    logic [7:0] log_mem [0:255];
    int         log_n      = 0;
    int         rdreq_n    = 0;
    int         fd_n       = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    // Monitor: log accepted bytes, count pulses, check hold while stalled.
    initial begin
        forever begin
            @(negedge SYS_CLK);
            if (RST) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    total = total + 1;
                    if (!TX_VALID || (TX_DATA != prev_data)) begin
                        bad = bad + 1;
                        $display("FAIL tx_hold: valid=%0b data=%02h required valid=1 data=%02h",
                                 TX_VALID, TX_DATA, prev_data);
                    end
                end
                if (TX_VALID && TX_READY) begin
                    $display("tx byte #%0d = %02h", log_n, TX_DATA);
                    log_mem[log_n % 256] = TX_DATA;
                    log_n = log_n + 1;
                end
                if (IMG_RDREQ)  rdreq_n = rdreq_n + 1;
                if (FRAME_DONE) fd_n    = fd_n + 1;
                prev_stall = TX_VALID && !TX_READY;
                prev_data  = TX_DATA;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_frame(input string tag, input int base, input logic [63:0] exp);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            e = exp[63 - 8*i -: 8];
            check($sformatf("%s_byte%0d", tag, i), 32'(log_mem[(base + i) % 256]), 32'(e));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_outputs"},
              {18'd0, TX_VALID, TX_DATA, IMG_RDREQ, MSG_READY, FRAME_DONE, ERR},
              32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
    endtask

    task automatic start_frame(input string tag);
        int i;
        i = 0;
        FRAME_REQ = 1'b1;
        do begin
            @(negedge SYS_CLK);
            i = i + 1;
        end while (!BUSY && i < 50);
        check({tag, "_start_busy"}, 32'(BUSY), 32'd1);
        @(posedge SYS_CLK);
        #1;
        FRAME_REQ = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int target);
        int i;
        i = 0;
        while (fd_n < target && i < 2000) begin
            @(negedge SYS_CLK);
            #1;
            i = i + 1;
        end
        check({tag, "_done_seen"}, 32'(fd_n >= target), 32'd1);
    endtask

    task automatic wait_log(input string tag, input int target);
        int i;
        i = 0;
        while (log_n < target && i < 2000) begin
            @(negedge SYS_CLK);
            #1;
            i = i + 1;
        end
        check({tag, "_log_seen"}, 32'(log_n >= target), 32'd1);
    endtask

    // ---------------- frame vector table
    typedef struct packed {
        int          ready_mode;
        int          gap;
        logic [63:0] exp;
        int          exp_rd;
    } vec_t;

    vec_t vecs [3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_log, base_rd, base_fd;
        logic       any_valid;
        logic [7:0] e;
        logic [7:0] arb_exp [0:18];

        vecs[0] = '{ready_mode: 0, gap: 0, exp: 64'h01FE_A0A1_A2A3_FE01, exp_rd: 4};
        vecs[1] = '{ready_mode: 1, gap: 0, exp: 64'h01FE_A0A1_A2A3_FE01, exp_rd: 4};
        vecs[2] = '{ready_mode: 0, gap: 1, exp: 64'h01FE_A0A1_A2A3_FE01, exp_rd: 4};

        arb_exp = '{8'h01, 8'hFE, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hFE, 8'h01,
                    8'hB0, 8'hB1, 8'hB2,
                    8'h01, 8'hFE, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hFE, 8'h01};

        // ---- reset state
        repeat (2) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        check_outputs_zero("reset");
        @(posedge SYS_CLK);
        #1;
        RST = 1'b0;
        repeat (2) @(posedge SYS_CLK);
        #1;

        // ---- table-driven frames
        for (int v = 0; v < 3; v++) begin
            base_log   = log_n;
            base_rd    = rdreq_n;
            base_fd    = fd_n;
            ready_mode = vecs[v].ready_mode;
            push(8'hA0);
            push(8'hA1);
            if (vecs[v].gap == 0) begin
                push(8'hA2);
                push(8'hA3);
            end
            start_frame($sformatf("vec%0d", v));
            if (vecs[v].gap != 0) begin
                any_valid = 1'b0;
                for (int c = 0; c < GAP_CYC; c++) begin
                    @(negedge SYS_CLK);
                    if (c >= 20 && TX_VALID) any_valid = 1'b1;
                end
                check("gap_tx_valid_low", 32'(any_valid), 32'd0);
                @(posedge SYS_CLK);
                #1;
                push(8'hA2);
                push(8'hA3);
            end
            wait_fd($sformatf("vec%0d", v), base_fd + 1);
            repeat (3) @(posedge SYS_CLK);
            #1;
            check_frame($sformatf("vec%0d", v), base_log, vecs[v].exp);
            check($sformatf("vec%0d_rdreq", v), 32'(rdreq_n - base_rd), 32'(vecs[v].exp_rd));
            check($sformatf("vec%0d_frame_done", v), 32'(fd_n - base_fd), 32'd1);
            check($sformatf("vec%0d_bytes", v), 32'(log_n - base_log), 32'd8);
            ready_mode = 0;
        end

        // ---- arbitration: frame and message both pending out of reset
        RST = 1'b1;
        @(posedge SYS_CLK);
        #1;
        RST = 1'b0;
        base_log = log_n;
        base_rd  = rdreq_n;
        base_fd  = fd_n;
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        msg_push(8'hB0, 1'b0);
        msg_push(8'hB1, 1'b0);
        msg_push(8'hB2, 1'b1);
        FRAME_REQ = 1'b1;
        wait_log("arb_second_frame", base_log + 12);
        @(posedge SYS_CLK);
        #1;
        FRAME_REQ = 1'b0;
        wait_fd("arb", base_fd + 2);
        repeat (3) @(posedge SYS_CLK);
        #1;
        for (int i = 0; i < 19; i++) begin
            e = arb_exp[i];
            check($sformatf("arb_byte%0d", i), 32'(log_mem[(base_log + i) % 256]), 32'(e));
        end
        check("arb_rdreq", 32'(rdreq_n - base_rd), 32'd8);
        check("arb_frame_done", 32'(fd_n - base_fd), 32'd2);
        check("arb_busy_end", 32'(BUSY), 32'd0);

        // ---- reset in the middle of a frame
        base_log = log_n;
        base_fd  = fd_n;
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        start_frame("midrst");
        wait_log("midrst_fifth", base_log + 5);
        @(posedge SYS_CLK);
        #1;
        RST = 1'b1;
        @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        check_outputs_zero("midrst");
        @(posedge SYS_CLK);
        #1;
        RST = 1'b0;
        repeat (4) @(posedge SYS_CLK);
        #1;
        check("midrst_bytes_sent", 32'(log_n - base_log), 32'd5);
        check("midrst_no_done", 32'(fd_n - base_fd), 32'd0);

        base_log = log_n;
        base_rd  = rdreq_n;
        base_fd  = fd_n;
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        start_frame("after_rst");
        wait_fd("after_rst", base_fd + 1);
        repeat (3) @(posedge SYS_CLK);
        #1;
        check_frame("after_rst", base_log, 64'h01FE_A0A1_A2A3_FE01);
        check("after_rst_rdreq", 32'(rdreq_n - base_rd), 32'd4);

`ifdef UART_SCHED_TIMEOUT_EN
        // ---- underrun watchdog: FIFO runs dry after one byte
        base_log = log_n;
        base_rd  = rdreq_n;
        base_fd  = fd_n;
        push(8'hA0);
        start_frame("timeout");
        wait_fd("timeout", base_fd + 1);
        repeat (3) @(posedge SYS_CLK);
        #1;
        check_frame("timeout", base_log, 64'h01FE_A000_0000_FE01);
        check("timeout_rdreq", 32'(rdreq_n - base_rd), 32'd1);
        check("timeout_err", 32'(ERR), 32'd1);
`else
        check("err_stays_low", 32'(ERR), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
